// File: rtl/connect_n_engine.sv
// rtl/connect_n_engine.sv - Connect-N game engine with fixed-latency win check around the last drop
module connect_n_engine #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int WIN  = 4,
  parameter int CW   = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 move_valid,
  input  logic [CW-1:0]        move_col,
  output logic                 move_ready,
  output logic [ROWS*COLS-1:0] board_occ,
  output logic [ROWS*COLS-1:0] board_owner,
  output logic                 turn,
  output logic                 move_done,
  output logic                 error,
  output logic [1:0]           result,
  output logic                 game_over
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(N + 1);
  localparam int KW = $clog2(WIN + 1);
  localparam int NC = 1 << CW;

  typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, OVER} state_t;

  state_t          state;
  logic [HW-1:0]   height [NC];
  logic [MW-1:0]   move_cnt;
  logic [HW-1:0]   lr;
  logic [CW-1:0]   lc;
  logic            lp;
  logic [KW-1:0]   k;
  logic [3:0]      pos_alive, neg_alive;
  logic [KW-1:0]   pos_cnt [4];
  logic [KW-1:0]   neg_cnt [4];
  logic [3:0]      pos_hit, neg_hit;
  logic            col_ok;
  logic            win;
  logic [IW-1:0]   drop_idx;

  assign move_ready = (state == IDLE);
  assign game_over  = (result != 2'b00);

  function automatic logic cell_match(input int rr, input int cc,
                                      input logic [N-1:0] o, input logic [N-1:0] w,
                                      input logic p);
    int idx;
    idx = rr * COLS + cc;
    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
    return o[idx[IW-1:0]] && (w[idx[IW-1:0]] == p);
  endfunction

  // Direction d: 0=(0,1) 1=(1,0) 2=(1,1) 3=(1,-1); both sides probed at distance k
  always_comb begin
    int dr, dc, rr, cc;
    pos_hit = '0;
    neg_hit = '0;
    dr = 0; dc = 0; rr = 0; cc = 0;
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      rr = int'(lr) + dr * int'(k);
      cc = int'(lc) + dc * int'(k);
      pos_hit[d] = cell_match(rr, cc, board_occ, board_owner, lp);
      rr = int'(lr) - dr * int'(k);
      cc = int'(lc) - dc * int'(k);
      neg_hit[d] = cell_match(rr, cc, board_occ, board_owner, lp);
    end
  end

  always_comb begin
    int tot;
    int di;
    tot = 0;
    win = 1'b0;
    for (int d = 0; d < 4; d++) begin
      tot = int'(pos_cnt[d]) + int'(neg_cnt[d]) + 1;
      if (tot >= WIN) win = 1'b1;
    end
    col_ok = (int'(move_col) < COLS) && (int'(height[move_col]) < ROWS);
    di = int'(height[move_col]) * COLS + int'(move_col);
    drop_idx = di[IW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      board_occ   <= '0;
      board_owner <= '0;
      turn        <= 1'b0;
      result      <= 2'b00;
      move_done   <= 1'b0;
      error       <= 1'b0;
      move_cnt    <= '0;
      lr          <= '0;
      lc          <= '0;
      lp          <= 1'b0;
      k           <= '0;
      pos_alive   <= '0;
      neg_alive   <= '0;
      for (int i = 0; i < NC; i++) height[i] <= '0;
      for (int d = 0; d < 4; d++) begin
        pos_cnt[d] <= '0;
        neg_cnt[d] <= '0;
      end
    end else begin
      move_done <= 1'b0;
      error     <= 1'b0;
      if (new_game) begin
        state       <= IDLE;
        board_occ   <= '0;
        board_owner <= '0;
        turn        <= 1'b0;
        result      <= 2'b00;
        move_cnt    <= '0;
        for (int i = 0; i < NC; i++) height[i] <= '0;
      end else begin
        case (state)
          IDLE: if (move_valid) begin
            if (!col_ok) begin
              error <= 1'b1;
            end else begin
              board_occ[drop_idx]   <= 1'b1;
              board_owner[drop_idx] <= turn;
              height[move_col]      <= height[move_col] + 1'b1;
              move_cnt              <= move_cnt + 1'b1;
              lr        <= height[move_col];
              lc        <= move_col;
              lp        <= turn;
              k         <= KW'(1);
              pos_alive <= '1;
              neg_alive <= '1;
              for (int d = 0; d < 4; d++) begin
                pos_cnt[d] <= '0;
                neg_cnt[d] <= '0;
              end
              state <= CHECK;
            end
          end
          CHECK: begin
            for (int d = 0; d < 4; d++) begin
              if (pos_alive[d] && pos_hit[d]) pos_cnt[d] <= pos_cnt[d] + 1'b1;
              else pos_alive[d] <= 1'b0;
              if (neg_alive[d] && neg_hit[d]) neg_cnt[d] <= neg_cnt[d] + 1'b1;
              else neg_alive[d] <= 1'b0;
            end
            k <= k + 1'b1;
            if (int'(k) == WIN - 1) state <= RESOLVE;
          end
          RESOLVE: begin
            move_done <= 1'b1;
            if (win) begin
              result <= lp ? 2'b10 : 2'b01;
              state  <= OVER;
            end else if (int'(move_cnt) == N) begin
              result <= 2'b11;
              state  <= OVER;
            end else begin
              turn  <= ~turn;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_connect_n_engine.sv
// tb/tb_connect_n_engine.sv - directed bench for connect_n_engine (default, 5x8/WIN5, 3x3/WIN3)
module tb_connect_n_engine;
  logic clk = 1'b0;
  logic reset, ng;
  logic [2:0] mv;
  logic [2:0] mc_a, mc_b;
  logic [1:0] mc_c;
  logic rdy_a, rdy_b, rdy_c, tn_a, tn_b, tn_c, md_a, md_b, md_c, er_a, er_b, er_c, go_a, go_b, go_c;
  logic [1:0] res_a, res_b, res_c;
  logic [41:0] occ_a, own_a;
  logic [39:0] occ_b, own_b;
  logic [8:0]  occ_c, own_c;
  logic [2:0] md, er;
  int total = 0;
  int bad = 0;

  assign md = {md_c, md_b, md_a};
  assign er = {er_c, er_b, er_a};

  always #5 clk = ~clk;

  connect_n_engine dut_a (
    .clk(clk), .reset(reset), .new_game(ng), .move_valid(mv[0]), .move_col(mc_a),
    .move_ready(rdy_a), .board_occ(occ_a), .board_owner(own_a), .turn(tn_a),
    .move_done(md_a), .error(er_a), .result(res_a), .game_over(go_a));

  connect_n_engine #(.ROWS(5), .COLS(8), .WIN(5)) dut_b (
    .clk(clk), .reset(reset), .new_game(ng), .move_valid(mv[1]), .move_col(mc_b),
    .move_ready(rdy_b), .board_occ(occ_b), .board_owner(own_b), .turn(tn_b),
    .move_done(md_b), .error(er_b), .result(res_b), .game_over(go_b));

  connect_n_engine #(.ROWS(3), .COLS(3), .WIN(3)) dut_c (
    .clk(clk), .reset(reset), .new_game(ng), .move_valid(mv[2]), .move_col(mc_c),
    .move_ready(rdy_c), .board_occ(occ_c), .board_owner(own_c), .turn(tn_c),
    .move_done(md_c), .error(er_c), .result(res_c), .game_over(go_c));

  task automatic play(input int inst, input int col, output int lat, output bit err_seen);
    @(negedge clk);
    case (inst)
      0: mc_a = 3'(col);
      1: mc_b = 3'(col);
      default: mc_c = 2'(col);
    endcase
    mv[inst] = 1'b1;
    @(negedge clk);
    mv[inst] = 1'b0;
    err_seen = er[inst];
    lat = 0;
    if (!err_seen)
      for (int i = 1; i <= 20 && lat == 0; i++) begin
        @(negedge clk);
        if (md[inst]) lat = i;
      end
  endtask

  task automatic start_game();
    @(negedge clk);
    ng = 1'b1;
    @(negedge clk);
    ng = 1'b0;
  endtask

  task automatic test_reset();
    total++; if ({rdy_a, tn_a, md_a, er_a, go_a, res_a} !== 7'b1000000) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {rdy_a, tn_a, md_a, er_a, go_a, res_a}, 7'b1000000); end
    total++; if (occ_a !== 42'd0 || own_a !== 42'd0) begin bad++;
      $display("FAIL reset_board got occ=%h own=%h exp=0", occ_a, own_a); end
    total++; if (occ_b !== 40'd0 || occ_c !== 9'd0 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin bad++;
      $display("FAIL reset_other got occ_b=%h occ_c=%h rdy=%b%b exp=0,0,11", occ_b, occ_c, rdy_b, rdy_c); end
  endtask

  task automatic test_horizontal();
    int cols[$] = '{0, 0, 1, 1, 2, 2, 3};
    int lat; bit e; logic [41:0] occ_snap;
    start_game();
    for (int i = 0; i < cols.size(); i++) begin
      play(0, cols[i], lat, e);
      if (i < cols.size() - 1) begin
        total++; if ({res_a, tn_a} !== {2'b00, 1'((i + 1) % 2)}) begin bad++;
          $display("FAIL horiz_mid%0d got res/turn=%b exp=%b", i, {res_a, tn_a}, {2'b00, 1'((i + 1) % 2)}); end
      end
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL horiz_latency got=%0d exp=4", lat); end
    total++; if (res_a !== 2'b01 || go_a !== 1'b1 || rdy_a !== 1'b0) begin bad++;
      $display("FAIL horiz_result got res=%b go=%b rdy=%b exp res=01 go=1 rdy=0", res_a, go_a, rdy_a); end
    total++; if (occ_a !== 42'h38F || own_a !== 42'h380) begin bad++;
      $display("FAIL horiz_board got occ=%h own=%h exp occ=38f own=380", occ_a, own_a); end
    occ_snap = occ_a;
    @(negedge clk); mc_a = 3'd4; mv[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({er_a, md_a, rdy_a} !== 3'b000 || occ_a !== occ_snap) begin bad++;
        $display("FAIL over_ignore got er/md/rdy=%b occ=%h exp 000 occ=%h", {er_a, md_a, rdy_a}, occ_a, occ_snap); end
    end
    mv[0] = 1'b0;
  endtask

  task automatic test_vertical();
    int cols[$] = '{0, 6, 1, 6, 0, 6, 1, 6};
    int lat; bit e;
    start_game();
    for (int i = 0; i < cols.size(); i++) play(0, cols[i], lat, e);
    total++; if (lat !== 4 || res_a !== 2'b10) begin bad++;
      $display("FAIL vert_result got lat=%0d res=%b exp lat=4 res=10", lat, res_a); end
    total++; if (own_a !== 42'h008102040 || occ_a !== 42'h0081021C3) begin bad++;
      $display("FAIL vert_board got occ=%h own=%h exp occ=81021c3 own=8102040", occ_a, own_a); end
  endtask

  task automatic test_diag_up();
    int cols[$] = '{0, 1, 1, 2, 2, 3, 2, 3, 3, 6, 3};
    int lat; bit e; int mid_bad = 0;
    start_game();
    for (int i = 0; i < cols.size(); i++) begin
      play(0, cols[i], lat, e);
      if (i < cols.size() - 1 && res_a !== 2'b00) mid_bad++;
    end
    total++; if (mid_bad !== 0) begin bad++; $display("FAIL diag_up_early got=%0d early results exp=0", mid_bad); end
    total++; if (lat !== 4 || res_a !== 2'b01 || go_a !== 1'b1) begin bad++;
      $display("FAIL diag_up_result got lat=%0d res=%b go=%b exp 4 01 1", lat, res_a, go_a); end
  endtask

  task automatic test_diag_down();
    int cols[$] = '{0, 6, 5, 5, 4, 4, 3, 4, 3, 3, 0, 3};
    int lat; bit e;
    start_game();
    for (int i = 0; i < cols.size(); i++) begin
      play(0, cols[i], lat, e);
      if (i == 6) begin
        total++; if (res_a !== 2'b00) begin bad++;
          $display("FAIL blocked_run3 got res=%b exp=00", res_a); end
      end
    end
    total++; if (lat !== 4 || res_a !== 2'b10) begin bad++;
      $display("FAIL diag_down_result got lat=%0d res=%b exp 4 10", lat, res_a); end
  endtask

  task automatic test_errors();
    int lat; bit e; int dones = 0;
    logic [41:0] exp_occ, exp_own;
    start_game();
    play(0, 7, lat, e);
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (md_a) dones++; end
    total++; if (e !== 1'b1 || dones !== 0) begin bad++;
      $display("FAIL err_badcol got err=%b dones=%0d exp err=1 dones=0", e, dones); end
    total++; if (occ_a !== 42'd0 || tn_a !== 1'b0) begin bad++;
      $display("FAIL err_badcol_state got occ=%h turn=%b exp 0 0", occ_a, tn_a); end
    for (int i = 0; i < 6; i++) play(0, 2, lat, e);
    exp_occ = '0; exp_own = '0;
    for (int r = 0; r < 6; r++) begin
      exp_occ[r * 7 + 2] = 1'b1;
      exp_own[r * 7 + 2] = 1'(r % 2);
    end
    play(0, 2, lat, e);
    total++; if (e !== 1'b1 || lat !== 0) begin bad++;
      $display("FAIL err_full got err=%b lat=%0d exp err=1 lat=0", e, lat); end
    total++; if (occ_a !== exp_occ || own_a !== exp_own || tn_a !== 1'b0 || res_a !== 2'b00) begin bad++;
      $display("FAIL err_full_state got occ=%h own=%h turn=%b res=%b exp occ=%h own=%h 0 00",
               occ_a, own_a, tn_a, res_a, exp_occ, exp_own); end
    @(negedge clk); mc_a = 3'd7; mv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (er_a !== 1'b1) begin bad++; $display("FAIL err_held%0d got=%b exp=1", i, er_a); end
    end
    mv[0] = 1'b0;
    @(negedge clk);
    total++; if (er_a !== 1'b0) begin bad++; $display("FAIL err_release got=%b exp=0", er_a); end
  endtask

  task automatic test_draw();
    int cols[$];
    int lat; bit e;
    logic [41:0] exp_own;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin cols.push_back(2 * p); cols.push_back(2 * p + 1); end
      for (int i = 0; i < 3; i++) begin cols.push_back(2 * p + 1); cols.push_back(2 * p); end
    end
    for (int i = 0; i < 3; i++) begin cols.push_back(4); cols.push_back(5); end
    for (int i = 0; i < 3; i++) begin cols.push_back(6); cols.push_back(4); end
    for (int i = 0; i < 3; i++) begin cols.push_back(5); cols.push_back(6); end
    start_game();
    for (int i = 0; i < cols.size(); i++) begin
      play(0, cols[i], lat, e);
      if (i == 40) begin
        total++; if (res_a !== 2'b00 || rdy_a !== 1'b1) begin bad++;
          $display("FAIL draw_move41 got res=%b rdy=%b exp 00 1", res_a, rdy_a); end
      end
    end
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) exp_own[r * 7 + c] = 1'(c % 2) ^ (r >= 3);
    total++; if (lat !== 4 || res_a !== 2'b11 || go_a !== 1'b1) begin bad++;
      $display("FAIL draw_result got lat=%0d res=%b go=%b exp 4 11 1", lat, res_a, go_a); end
    total++; if (occ_a !== {42{1'b1}} || own_a !== exp_own) begin bad++;
      $display("FAIL draw_board got occ=%h own=%h exp occ=all own=%h", occ_a, own_a, exp_own); end
  endtask

  task automatic test_new_game_mid_check();
    int lat; bit e; int dones = 0;
    start_game();
    play(0, 0, lat, e);
    @(negedge clk); mc_a = 3'd3; mv[0] = 1'b1;
    @(negedge clk); mv[0] = 1'b0;
    total++; if (occ_a[3] !== 1'b1 || rdy_a !== 1'b0) begin bad++;
      $display("FAIL ng_accept got occ3=%b rdy=%b exp 1 0", occ_a[3], rdy_a); end
    ng = 1'b1;
    @(negedge clk); ng = 1'b0;
    if (md_a) dones++;
    total++; if (occ_a !== 42'd0 || own_a !== 42'd0 || tn_a !== 1'b0 || res_a !== 2'b00 || rdy_a !== 1'b1) begin bad++;
      $display("FAIL ng_clear got occ=%h own=%h turn=%b res=%b rdy=%b exp 0 0 0 00 1", occ_a, own_a, tn_a, res_a, rdy_a); end
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (md_a) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL ng_no_done got=%0d exp=0", dones); end
    play(0, 5, lat, e);
    total++; if (lat !== 4 || occ_a !== (42'd1 << 5)) begin bad++;
      $display("FAIL ng_after got lat=%0d occ=%h exp 4 20", lat, occ_a); end
  endtask

  task automatic test_reset_mid_check();
    int lat; bit e;
    start_game();
    play(0, 1, lat, e);
    @(negedge clk); mc_a = 3'd2; mv[0] = 1'b1;
    @(negedge clk); mv[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (occ_a !== 42'd0 || tn_a !== 1'b0 || rdy_a !== 1'b1 || md_a !== 1'b0) begin bad++;
      $display("FAIL async_reset got occ=%h turn=%b rdy=%b md=%b exp 0 0 1 0", occ_a, tn_a, rdy_a, md_a); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_wide_board();
    int cols[$] = '{3, 0, 4, 0, 5, 0, 6, 0, 7};
    int lat; bit e;
    start_game();
    for (int i = 0; i < cols.size(); i++) play(1, cols[i], lat, e);
    total++; if (lat !== 5 || res_b !== 2'b01 || go_b !== 1'b1) begin bad++;
      $display("FAIL wide_result got lat=%0d res=%b go=%b exp 5 01 1", lat, res_b, go_b); end
    total++; if (occ_b !== 40'h00010101F9 || own_b !== 40'h0001010101) begin bad++;
      $display("FAIL wide_board got occ=%h own=%h exp occ=10101f9 own=1010101", occ_b, own_b); end
  endtask

  task automatic test_fill_win();
    int cols[$] = '{0, 1, 1, 0, 0, 2, 2, 1, 2};
    int lat; bit e;
    start_game();
    for (int i = 0; i < cols.size(); i++) begin
      play(2, cols[i], lat, e);
      if (i == 7) begin
        total++; if (res_c !== 2'b00 || tn_c !== 1'b0) begin bad++;
          $display("FAIL fill_move8 got res=%b turn=%b exp 00 0", res_c, tn_c); end
      end
    end
    total++; if (lat !== 3 || res_c !== 2'b01 || occ_c !== 9'h1FF) begin bad++;
      $display("FAIL fill_win got lat=%0d res=%b occ=%h exp 3 01 1ff", lat, res_c, occ_c); end
  endtask

  initial begin
    reset = 1'b1; ng = 1'b0; mv = '0; mc_a = '0; mc_b = '0; mc_c = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_horizontal();
    test_vertical();
    test_diag_up();
    test_diag_down();
    test_errors();
    test_draw();
    test_new_game_mid_check();
    test_reset_mid_check();
    test_wide_board();
    test_fill_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/connect_n_engine.md
# connect_n_engine

Parametrised Connect-N game engine for the board-game FPGA project. It keeps a ROWS×COLS board and accepts column drops through a valid/ready handshake. After each drop it runs a fixed-latency win check centred on the new piece, then reports win, draw or turn change. It feeds the LED/display driver and takes moves from the switch/button input decoder.

## Interface
- ROWS, 6, board height (≥ WIN)
- COLS, 7, board width (≥ WIN)
- WIN, 4, run length needed to win (2..8)
- CW, $clog2(COLS), column index width
- N, ROWS*COLS, cell count (derived, not overridable)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- new_game  in  1  synchronous clear of board and result; accepted in any state
- move_valid  in  1  move request
- move_col  in  CW  binary column index; 0 = leftmost
- move_ready  out  1  engine can accept a move
- board_occ  out  N  cell occupied; bit r*COLS+c, row 0 = bottom
- board_owner  out  N  cell owner (0 = P1, 1 = P2); valid only where occupied
- turn  out  1  player to move (0 = P1, 1 = P2)
- move_done  out  1  one-cycle pulse: an accepted move has been resolved
- error  out  1  one-cycle pulse: rejected move (col ≥ COLS or column full)
- result  out  2  00 in play, 01 P1 win, 10 P2 win, 11 draw
- game_over  out  1  high when result ≠ 00

## Operation
- States: IDLE, CHECK, RESOLVE, OVER. move_ready = (state == IDLE).
- Each column has a height counter (0..ROWS). Drop row = height[col]. No scanning.
- IDLE, handshake (move_valid & move_ready):
  - col ≥ COLS or height == ROWS: error pulses and the state stays IDLE. Board and turn are unchanged.
  - Otherwise: set occ/owner at (height, col) to turn, increment height and the move counter, latch (r, c, turn), clear the run counters, set k = 1, and go to CHECK.
- CHECK, step k = 1..WIN-1, one step per cycle. Four directions: (0,1), (1,0), (1,1), (1,-1). Each direction walks both + and −.
  - A side's run stays alive while cell (r±k·dr, c±k·dc) is in bounds, occupied, and owned by the latched player.
  - A live side adds 1 to its count. A side that dies stays dead.
- After step WIN-1, go to RESOLVE.
- RESOLVE:
  - Win if any direction has pos+neg+1 ≥ WIN. Set result to 01/10 and go to OVER.
  - Otherwise, if the move counter == N, set result = 11 and go to OVER.
  - Otherwise toggle turn and go to IDLE.
  - move_done pulses in all three cases.
- OVER: moves are ignored (move_ready = 0, no error). The engine holds until new_game or reset.
- new_game (priority over everything): clears occ, owner, heights and the move counter. Sets turn = 0, result = 00 and state IDLE. It aborts an in-flight CHECK/RESOLVE with no move_done pulse.
- Win is tested before draw: a filling move that completes a run is a win.

## Timing
- Reset values: state IDLE, board_occ = 0, board_owner = 0, heights = 0, turn = 0, result = 00, game_over = 0, move_ready = 1, move_done = 0, error = 0.
- The move is accepted at edge T. The cell is visible on board_occ after T, and move_ready is low after T.
- CHECK occupies edges T+1 .. T+WIN-1. RESOLVE is at edge T+WIN.
- move_done, result and turn update after edge T+WIN. move_ready is high again the same cycle if not over.
- Accept-to-resolve latency = WIN cycles. Move throughput is one per WIN+1 cycles.
- error is asserted in the cycle after the rejecting edge, for exactly 1 cycle. A held move_valid with a bad column re-pulses error every cycle.
- Board outputs are registered. The check reads only the registered board; the new cell is already written at T.
- Reset mid-CHECK returns to the reset values immediately (asynchronous).

## Test plan
- Default params: P1 plays col 0,1,2,3 and P2 plays col 0,1,2 (interleaved) -> P1's 4th move gives move_done with result = 01 and game_over = 1 exactly 4 cycles after accept. move_ready stays 0 afterwards.
- Vertical P2 win: P1 plays 0,1,0,1 interleaved with P2 on col 6 ×4 -> result = 10 after P2's 4th drop. board_owner bits 6,13,20,27 = 1.
- Diagonal (1,-1) and (1,1) wins built with staircase fills -> the matching winner is reported. A run of 3 plus an opposing piece gives no win.
- Error paths: move_col = 7, then 7 drops into col 2 -> error pulses on the bad column and on the 7th drop. Board and turn are unchanged, and no move_done.
- Draw: scripted no-win fill of all 42 cells -> after the 42nd move result = 11. A filling move that wins reports 01/10 instead.
- new_game asserted during CHECK -> board = 0, turn = 0, no move_done. Also ROWS = 5, COLS = 8, WIN = 5 with a horizontal P1 run on cols 3..7 -> result = 01 after 5 cycles.
